tm1638_frame_tx: RTL and testbench

//  Serial transmitter for the TM1638 LED/key board. Sits directly downstream of the

---
 rtl/tm1638_frame_tx.sv | 199 +++++++++++++++++++
 tb/tb_tm1638_frame_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_frame_tx.sv
// TM1638 write-only frame transmitter: latches eight digit bytes, eight LED bits and the
// display enable on start, then sends 0x40 | 0xC0 + 16 data bytes | display-control on STB/CLK/DIO.
//
// state | meaning
// IDLE  | waiting for start, lines idle high
// T1    | command 0x40 (write, auto-increment)
// GAP1  | stb high between T1 and T2
// T2    | 0xC0 then 16 data bytes, addresses 0..15
// GAP2  | stb high between T2 and T3
// T3    | display-control command
// GAP3  | final stb-high gap, done pulses as it ends
module tm1638_frame_tx #(
   parameter int         CLK_DIV    = 25,
   parameter logic [2:0] BRIGHTNESS = 3'd7
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        start,
   input  logic [63:0] seg_data,
   input  logic [7:0]  led,
   input  logic        display_on,
   output logic        busy,
   output logic        done,
   output logic        stb,
   output logic        TM_clk,
   output logic        dio
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_T1, S_GAP1, S_T2, S_GAP2, S_T3, S_GAP3
   } state_t;

   // Inside gaps, P_SETUP and P_LOW are simply the first and second stb-high units.
   typedef enum logic [1:0] {P_SETUP, P_LOW, P_HIGH, P_HOLD} phase_t;

   state_t        state, state_n;
   phase_t        phase, phase_n;
   logic [DW-1:0] div_cnt, div_n;
   logic [2:0]    bit_cnt, bit_n, bit_inc;
   logic [4:0]    byte_cnt, byte_n, byte_inc;
   logic [63:0]   sh_seg;
   logic [7:0]    sh_led;
   logic          sh_disp;
   logic          stb_n, clk_n, dio_n, done_n, load, tick, last_byte;
   logic [7:0]    cur_byte, next_byte;

   // Byte k of T2: k=0 is the address command, then even addresses carry digits, odd carry LEDs.
   function automatic logic [7:0] t2_byte(input logic [4:0] idx, input logic [63:0] seg,
                                          input logic [7:0] leds);
      logic [3:0] addr;
      addr = 4'(idx - 5'd1);
      if (idx == 5'd0)
         return 8'hC0;
      else if (!addr[0])
         return seg[8*addr[3:1] +: 8];
      else
         return {7'b0, leds[addr[3:1]]};
   endfunction

   assign busy     = (state != S_IDLE);
   assign tick     = (div_cnt == '0);
   assign bit_inc  = bit_cnt + 3'd1;
   assign byte_inc = byte_cnt + 5'd1;

   always_comb begin
      cur_byte = 8'h40;
      if (state == S_T2)
         cur_byte = t2_byte(byte_cnt, sh_seg, sh_led);
      else if (state == S_T3)
         cur_byte = sh_disp ? (8'h88 | {5'b0, BRIGHTNESS}) : 8'h80;
   end

   assign next_byte = t2_byte(byte_inc, sh_seg, sh_led);
   assign last_byte = (state == S_T2) ? (byte_cnt == 5'd16) : 1'b1;

   always_comb begin
      state_n = state;
      phase_n = phase;
      div_n   = div_cnt;
      bit_n   = bit_cnt;
      byte_n  = byte_cnt;
      stb_n   = stb;
      clk_n   = TM_clk;
      dio_n   = dio;
      done_n  = 1'b0;
      load    = 1'b0;
      if (state != S_IDLE)
         div_n = tick ? DIV_LOAD : div_cnt - DW'(1);
      unique case (state)
         S_IDLE: begin
            // A start landing in the done cycle is dropped rather than chained.
            if (start && !done) begin
               load    = 1'b1;
               state_n = S_T1;
               phase_n = P_SETUP;
               div_n   = DIV_LOAD;
               bit_n   = 3'd0;
               byte_n  = 5'd0;
               stb_n   = 1'b0;
            end
         end
         S_T1, S_T2, S_T3: begin
            if (tick) begin
               unique case (phase)
                  P_SETUP: begin
                     phase_n = P_LOW;
                     clk_n   = 1'b0;
                     dio_n   = cur_byte[0];
                  end
                  P_LOW: begin
                     phase_n = P_HIGH;
                     clk_n   = 1'b1;
                  end
                  P_HIGH: begin
                     if (bit_cnt == 3'd7) begin
                        bit_n = 3'd0;
                        if (last_byte) begin
                           phase_n = P_HOLD;
                        end else begin
                           byte_n  = byte_inc;
                           phase_n = P_LOW;
                           clk_n   = 1'b0;
                           dio_n   = next_byte[0];
                        end
                     end else begin
                        bit_n   = bit_inc;
                        phase_n = P_LOW;
                        clk_n   = 1'b0;
                        dio_n   = cur_byte[bit_inc];
                     end
                  end
                  P_HOLD: begin
                     stb_n   = 1'b1;
                     dio_n   = 1'b1;
                     phase_n = P_SETUP;
                     state_n = (state == S_T1) ? S_GAP1 : (state == S_T2) ? S_GAP2 : S_GAP3;
                  end
               endcase
            end
         end
         S_GAP1, S_GAP2, S_GAP3: begin
            if (tick) begin
               if (phase == P_SETUP) begin
                  phase_n = P_LOW;
               end else begin
                  phase_n = P_SETUP;
                  bit_n   = 3'd0;
                  byte_n  = 5'd0;
                  if (state == S_GAP3) begin
                     state_n = S_IDLE;
                     done_n  = 1'b1;
                     div_n   = '0;
                  end else begin
                     state_n = (state == S_GAP1) ? S_T2 : S_T3;
                     stb_n   = 1'b0;
                  end
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state    <= S_IDLE;
         phase    <= P_SETUP;
         div_cnt  <= '0;
         bit_cnt  <= 3'd0;
         byte_cnt <= 5'd0;
         stb      <= 1'b1;
         TM_clk   <= 1'b1;
         dio      <= 1'b1;
         done     <= 1'b0;
         sh_seg   <= 64'd0;
         sh_led   <= 8'd0;
         sh_disp  <= 1'b0;
      end else begin
         state    <= state_n;
         phase    <= phase_n;
         div_cnt  <= div_n;
         bit_cnt  <= bit_n;
         byte_cnt <= byte_n;
         stb      <= stb_n;
         TM_clk   <= clk_n;
         dio      <= dio_n;
         done     <= done_n;
         if (load) begin
            sh_seg  <= seg_data;
            sh_led  <= led;
            sh_disp <= display_on;
         end
      end
   end

endmodule

// File: tb/tb_tm1638_frame_tx.sv
// Scoreboard bench for tm1638_frame_tx: two instances (CLK_DIV 3/BRIGHTNESS 7 and CLK_DIV 2/BRIGHTNESS 3)
// decoded by a bus monitor that pops hand-computed bytes and transaction-end markers.
module tb_tm1638_frame_tx;

   localparam int CD0 = 3;
   localparam int CD1 = 2;
   localparam logic [8:0] END_TXN = 9'h100;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [1:0]  start;
   logic [63:0] seg_data;
   logic [7:0]  led;
   logic        display_on;
   logic [1:0]  busy, done, stb, tm_clk, dio;

   always #5 Clk = ~Clk;

   tm1638_frame_tx #(.CLK_DIV(CD0), .BRIGHTNESS(3'd7)) u_dut0 (
      .Clk(Clk), .Rst(Rst), .start(start[0]), .seg_data(seg_data), .led(led),
      .display_on(display_on), .busy(busy[0]), .done(done[0]), .stb(stb[0]),
      .TM_clk(tm_clk[0]), .dio(dio[0]));

   tm1638_frame_tx #(.CLK_DIV(CD1), .BRIGHTNESS(3'd3)) u_dut1 (
      .Clk(Clk), .Rst(Rst), .start(start[1]), .seg_data(seg_data), .led(led),
      .display_on(display_on), .busy(busy[1]), .done(done[1]), .stb(stb[1]),
      .TM_clk(tm_clk[1]), .dio(dio[1]));

   int errors = 0;
   int checks = 0;
   logic [8:0] q0[$];
   logic [8:0] q1[$];

   // Hand-decoded T2 payloads for the two data sets used below.
   logic [7:0] frame_a[17];
   logic [7:0] frame_b[17];
   localparam logic [63:0] SEG_A = 64'h7D6D4F067D5B5B06;
   localparam logic [7:0]  LED_A = 8'hA5;
   localparam logic [63:0] SEG_B = 64'h3F065B4F666D7D07;
   localparam logic [7:0]  LED_B = 8'h0F;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int g, input logic [8:0] v);
      if (g == 0) q0.push_back(v);
      else        q1.push_back(v);
   endtask

   task automatic pop_exp(input int g, output logic got, output logic [8:0] v);
      got = 1'b0;
      v   = 9'h0;
      if (g == 0 && q0.size() > 0) begin got = 1'b1; v = q0.pop_front(); end
      if (g == 1 && q1.size() > 0) begin got = 1'b1; v = q1.pop_front(); end
   endtask

   task automatic push_frame(input int g, input logic [7:0] t2[17], input logic [7:0] t3);
      push(g, 9'h040);
      push(g, END_TXN);
      for (int i = 0; i < 17; i++) push(g, {1'b0, t2[i]});
      push(g, END_TXN);
      push(g, {1'b0, t3});
      push(g, END_TXN);
   endtask

   task automatic pulse(input int g);
      @(negedge Clk) start[g] = 1'b1;
      @(negedge Clk) start[g] = 1'b0;
   endtask

   task automatic wait_done(input int g);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge Clk);
         if (done[g]) seen = 1'b1;
      end
      check($sformatf("done_timeout_%0d", g), {31'b0, seen}, 32'd1);
   endtask

   // Bus monitor: decodes bytes on TM_clk rises, checks framing, bit period and busy length.
   logic [7:0] sh[2];
   int         nbit[2];
   int         bits_txn[2];
   int         per[2];
   int         bcnt[2];
   logic [1:0] pstb, pclk, pdone;

   always @(negedge Clk) begin
      logic       got;
      logic [8:0] v;
      for (int g = 0; g < 2; g++) begin
         if (Rst) begin
            nbit[g] = 0; bits_txn[g] = 0; per[g] = 0; bcnt[g] = 0;
            pstb[g] = 1'b1; pclk[g] = 1'b1; pdone[g] = 1'b0;
         end else begin
            per[g]++;
            if (pstb[g] && !stb[g]) begin
               nbit[g] = 0;
               bits_txn[g] = 0;
            end
            if (!stb[g] && !pclk[g] && tm_clk[g]) begin
               if (bits_txn[g] > 0)
                  check("tm_clk_period", per[g], 2 * (g == 0 ? CD0 : CD1));
               per[g] = 0;
               bits_txn[g]++;
               sh[g] = {dio[g], sh[g][7:1]};
               nbit[g]++;
               if (nbit[g] == 8) begin
                  nbit[g] = 0;
                  pop_exp(g, got, v);
                  check($sformatf("byte_expected_%0d", g), {31'b0, got}, 32'd1);
                  if (got) check($sformatf("frame_byte_%0d", g), {24'b0, sh[g]}, {23'b0, v});
               end
            end
            if (!pstb[g] && stb[g]) begin
               pop_exp(g, got, v);
               check($sformatf("txn_end_%0d", g), {22'b0, got, v}, {22'b0, 1'b1, END_TXN});
               check("txn_partial_bits", nbit[g], 0);
               check("gap_dio_high", {31'b0, dio[g]}, 32'd1);
            end
            if (busy[g]) bcnt[g]++;
            if (done[g]) begin
               check("done_busy_low", {31'b0, busy[g]}, 32'd0);
               check($sformatf("busy_length_%0d", g), bcnt[g], 316 * (g == 0 ? CD0 : CD1));
               check("done_single_pulse", {31'b0, pdone[g]}, 32'd0);
               bcnt[g] = 0;
            end
            pstb[g]  = stb[g];
            pclk[g]  = tm_clk[g];
            pdone[g] = done[g];
         end
      end
   end

   initial begin
      frame_a = '{8'hC0, 8'h06, 8'h01, 8'h5B, 8'h00, 8'h5B, 8'h01, 8'h7D, 8'h00,
                  8'h06, 8'h00, 8'h4F, 8'h01, 8'h6D, 8'h00, 8'h7D, 8'h01};
      frame_b = '{8'hC0, 8'h07, 8'h01, 8'h7D, 8'h01, 8'h6D, 8'h01, 8'h66, 8'h01,
                  8'h4F, 8'h00, 8'h5B, 8'h00, 8'h06, 8'h00, 8'h3F, 8'h00};
      Rst = 1'b1;
      start = 2'b00;
      seg_data = 64'd0;
      led = 8'd0;
      display_on = 1'b0;
      #1;
      check("rst_stb", {30'b0, stb}, 32'h3);
      check("rst_tm_clk", {30'b0, tm_clk}, 32'h3);
      check("rst_dio", {30'b0, dio}, 32'h3);
      check("rst_busy", {30'b0, busy}, 32'h0);
      check("rst_done", {30'b0, done}, 32'h0);
      repeat (3) @(posedge Clk);
      #2 Rst = 1'b0;

      // Reference frame, display on, brightness 7.
      seg_data = SEG_A; led = LED_A; display_on = 1'b1;
      push_frame(0, frame_a, 8'h8F);
      pulse(0);
      wait_done(0);

      // CLK_DIV=2 instance, display off, then start presented in the done cycle.
      display_on = 1'b0;
      push_frame(1, frame_a, 8'h80);
      pulse(1);
      wait_done(1);
      start[1] = 1'b1;
      @(negedge Clk) start[1] = 1'b0;
      repeat (4) @(negedge Clk);
      check("start_in_done_ignored", {31'b0, busy[1]}, 32'd0);
      display_on = 1'b1;
      push_frame(1, frame_a, 8'h8B);
      pulse(1);
      wait_done(1);

      // Restart attempt and data change mid-T2 must not disturb the frame in flight.
      seg_data = SEG_A; led = LED_A; display_on = 1'b1;
      push_frame(0, frame_a, 8'h8F);
      pulse(0);
      repeat (300) @(negedge Clk);
      check("mid_t2_stb_low", {31'b0, stb[0]}, 32'd0);
      seg_data = SEG_B; led = LED_B; display_on = 1'b0;
      start[0] = 1'b1;
      @(negedge Clk) start[0] = 1'b0;
      wait_done(0);
      repeat (10) @(negedge Clk);
      check("no_second_frame", {31'b0, busy[0]}, 32'd0);
      check("queue0_drained", q0.size(), 0);

      // Reset during byte 9 of T2, then a clean frame.
      seg_data = SEG_A; led = LED_A; display_on = 1'b1;
      push_frame(0, frame_a, 8'h8F);
      pulse(0);
      repeat (519) @(negedge Clk);
      check("pre_reset_busy", {31'b0, busy[0]}, 32'd1);
      #($urandom_range(1, 4)) Rst = 1'b1;
      #1;
      check("abort_stb", {31'b0, stb[0]}, 32'd1);
      check("abort_tm_clk", {31'b0, tm_clk[0]}, 32'd1);
      check("abort_dio", {31'b0, dio[0]}, 32'd1);
      check("abort_busy", {31'b0, busy[0]}, 32'd0);
      check("abort_done", {31'b0, done[0]}, 32'd0);
      q0.delete();
      repeat (3) @(posedge Clk);
      #2 Rst = 1'b0;
      seg_data = SEG_B; led = LED_B; display_on = 1'b1;
      push_frame(0, frame_b, 8'h8F);
      pulse(0);
      wait_done(0);
      repeat (10) @(negedge Clk);
      check("queue0_empty", q0.size(), 0);
      check("queue1_empty", q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
